// File: rtl/z3_master_cycle_pkg.sv
// Shared constants for the Zorro III DMA master cycle engine:
// FSM state codes and NCR 53C710 transfer-size codes.
package z3_master_cycle_pkg;

    localparam logic [2:0] Z3M_IDLE    = 3'd0;
    localparam logic [2:0] Z3M_ADDR    = 3'd1;
    localparam logic [2:0] Z3M_STROBE  = 3'd2;
    localparam logic [2:0] Z3M_WAIT    = 3'd3;
    localparam logic [2:0] Z3M_TERM    = 3'd4;
    localparam logic [2:0] Z3M_ERR     = 3'd5;
    localparam logic [2:0] Z3M_RECOVER = 3'd6;

    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

endpackage

// File: rtl/z3_master_cycle_ds_lane_decode.sv
// SIZ/A to Zorro III byte-strobe mask (active low, ds_n_o[3] = lowest byte address).
module z3_master_cycle_ds_lane_decode
    import z3_master_cycle_pkg::*;
(
    input  logic [1:0] siz_i,
    input  logic [1:0] a_i,
    output logic [3:0] ds_n_o
);

    logic [3:0] lanes_from_zero;
    logic [3:0] lanes_en;

    // Lanes counted from byte 0 sit at the MSB end, so shifting right by A
    // moves them to the start address and drops anything past byte 3.
    always_comb begin
        case (siz_i)
            SIZ_BYTE:  lanes_from_zero = 4'b1000;
            SIZ_WORD:  lanes_from_zero = 4'b1100;
            SIZ_3BYTE: lanes_from_zero = 4'b1110;
            SIZ_LONG:  lanes_from_zero = 4'b1111;
        endcase
        lanes_en = lanes_from_zero >> a_i;
        ds_n_o   = ~lanes_en;
    end

endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle engine: turns one NCR local-bus master cycle into one
// FCS/DS/DTACK cycle; states IDLE > ADDR > STROBE > WAIT > TERM|ERR > RECOVER.
module z3_master_cycle
    import z3_master_cycle_pkg::*;
#(
    parameter logic [7:0] DTACK_TIMEOUT = 8'd255
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       BMASTER,
    input  logic       READ,
    input  logic [1:0] SIZ,
    input  logic [1:0] A,
    input  logic       SCSI_AS_n,
    input  logic       FCS_n,
    input  logic       ZORRO_DTACK_n,
    input  logic       BERR_n,
    output logic       DMA_FCS_n,
    output logic [3:0] DMA_DS_n,
    output logic       DMA_DOE,
    output logic       SCSI_STERM_n,
    output logic       SCSI_BERR_n,
    output logic       BFCS_out,
    output logic       dma_busy
);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       read_q, read_d;
    logic [1:0] siz_q, siz_d;
    logic [1:0] a_q, a_d;
    logic       fcs_q, fcs_d;
    logic [3:0] ds_q, ds_d;
    logic       doe_q, doe_d;
    logic       sterm_q, sterm_d;
    logic       berr_q, berr_d;
    logic       busy_q, busy_d;
    logic       bfcs_q;
    logic       dtack_s1_q, dtack_s2_q;
    logic       berr_s1_q, berr_s2_q;
    logic [3:0] lane_mask;

    z3_master_cycle_ds_lane_decode u_lane (
        .siz_i  (siz_q),
        .a_i    (a_q),
        .ds_n_o (lane_mask)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        read_d  = read_q;
        siz_d   = siz_q;
        a_d     = a_q;
        fcs_d   = fcs_q;
        ds_d    = ds_q;
        doe_d   = doe_q;
        sterm_d = 1'b1;
        berr_d  = 1'b1;
        // Losing the bus abandons the cycle silently from any active state.
        if (state_q != Z3M_IDLE && !BMASTER) begin
            state_d = Z3M_IDLE;
            fcs_d   = 1'b1;
            ds_d    = 4'b1111;
            doe_d   = 1'b0;
        end else begin
            case (state_q)
                Z3M_IDLE: begin
                    if (BMASTER && !SCSI_AS_n) begin
                        read_d  = READ;
                        siz_d   = SIZ;
                        a_d     = A;
                        state_d = Z3M_ADDR;
                    end
                end
                Z3M_ADDR: begin
                    fcs_d   = 1'b0;
                    state_d = Z3M_STROBE;
                end
                Z3M_STROBE: begin
                    ds_d    = lane_mask;
                    doe_d   = !read_q;
                    cnt_d   = 8'd0;
                    state_d = Z3M_WAIT;
                end
                Z3M_WAIT: begin
                    if (!dtack_s2_q) begin
                        sterm_d = 1'b0;
                        state_d = Z3M_TERM;
                    end else if (!berr_s2_q || cnt_q == DTACK_TIMEOUT) begin
                        berr_d  = 1'b0;
                        state_d = Z3M_ERR;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                Z3M_TERM, Z3M_ERR: begin
                    fcs_d   = 1'b1;
                    ds_d    = 4'b1111;
                    doe_d   = 1'b0;
                    state_d = Z3M_RECOVER;
                end
                Z3M_RECOVER: begin
                    if (SCSI_AS_n && dtack_s2_q) state_d = Z3M_IDLE;
                end
                default: state_d = Z3M_IDLE;
            endcase
        end
        busy_d = (state_d != Z3M_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= Z3M_IDLE;
            cnt_q      <= 8'd0;
            read_q     <= 1'b0;
            siz_q      <= SIZ_LONG;
            a_q        <= 2'd0;
            fcs_q      <= 1'b1;
            ds_q       <= 4'b1111;
            doe_q      <= 1'b0;
            sterm_q    <= 1'b1;
            berr_q     <= 1'b1;
            busy_q     <= 1'b0;
            bfcs_q     <= 1'b1;
            dtack_s1_q <= 1'b1;
            dtack_s2_q <= 1'b1;
            berr_s1_q  <= 1'b1;
            berr_s2_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            read_q     <= read_d;
            siz_q      <= siz_d;
            a_q        <= a_d;
            fcs_q      <= fcs_d;
            ds_q       <= ds_d;
            doe_q      <= doe_d;
            sterm_q    <= sterm_d;
            berr_q     <= berr_d;
            busy_q     <= busy_d;
            bfcs_q     <= FCS_n;
            dtack_s1_q <= ZORRO_DTACK_n;
            dtack_s2_q <= dtack_s1_q;
            berr_s1_q  <= BERR_n;
            berr_s2_q  <= berr_s1_q;
        end
    end

    assign DMA_FCS_n    = fcs_q;
    assign DMA_DS_n     = ds_q;
    assign DMA_DOE      = doe_q;
    assign SCSI_STERM_n = sterm_q;
    assign SCSI_BERR_n  = berr_q;
    assign BFCS_out     = bfcs_q;
    assign dma_busy     = busy_q;

endmodule
